// File: rtl/vtg_pkg.sv
// ---------------------------------------------------------------------------
// vtg_pkg
// Shared definitions for the video timing / test-pattern generator:
// runtime pattern codes and the eight colour-bar constants.
// No ports (package).
// ---------------------------------------------------------------------------
package vtg_pkg;

    // Runtime pattern selection codes
    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_e;

    // Colour bars, left to right
    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Map a bar index (0..7) to its {R,G,B} colour
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// video_timing_pattern_gen_if
// Control and video bus of the timing/pattern generator.
//   en, pat_sel        : run enable and pattern select (into the generator)
//   rgb_data           : 24-bit {R,G,B}, zero during blanking
//   vid_de/vid_hs/vid_vs : data enable and syncs
//   pix_x, pix_y       : active-area coordinates (0 outside active video)
//   frame_start        : one-cycle pulse on the first cycle of a frame
// master = generator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface video_timing_pattern_gen_if #(
    parameter int CNT_W = 13
);
    logic             en;
    logic [1:0]       pat_sel;
    logic [23:0]      rgb_data;
    logic             vid_de;
    logic             vid_hs;
    logic             vid_vs;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             frame_start;

    modport master (
        input  en, pat_sel,
        output rgb_data, vid_de, vid_hs, vid_vs, pix_x, pix_y, frame_start
    );

    modport slave (
        output en, pat_sel,
        input  rgb_data, vid_de, vid_hs, vid_vs, pix_x, pix_y, frame_start
    );
endinterface

// File: rtl/vtg_counter.sv
// ---------------------------------------------------------------------------
// vtg_counter
// Horizontal/vertical raster counters with region decode. Decoded outputs
// describe the current counter state and are registered by the parent.
//   sys_clk, sys_rst : pixel clock, synchronous active-high reset
//   en               : low forces and holds both counters at 0
//   hs_act, vs_act   : sync regions (true = sync asserted, polarity applied later)
//   de               : inside both active windows
//   x, y             : active-area coordinates, 0 outside active video
//   at_top           : counters at h=0, v=0 (first cycle of a frame)
// ---------------------------------------------------------------------------
module vtg_counter #(
    parameter int H_SYNC   = 44,
    parameter int H_BACK   = 148,
    parameter int H_ACTIVE = 1920,
    parameter int H_FRONT  = 88,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 36,
    parameter int V_ACTIVE = 1080,
    parameter int V_FRONT  = 4,
    parameter int CNT_W    = 13
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    output logic             hs_act,
    output logic             vs_act,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             at_top
);
    import vtg_pkg::*;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

    // Reject parameter sets the counters cannot represent
    generate
        if ((longint'(H_TOTAL) - 1 >= (longint'(1) << CNT_W)) ||
            (longint'(V_TOTAL) - 1 >= (longint'(1) << CNT_W))) begin : g_bad_cnt_w
            $error("vtg_counter: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
        if (H_SYNC < 1 || H_BACK < 1 || H_ACTIVE < 1 || H_FRONT < 1 ||
            V_SYNC < 1 || V_BACK < 1 || V_ACTIVE < 1 || V_FRONT < 1) begin : g_bad_seg
            $error("vtg_counter: every timing segment must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_in;
    logic             v_in;

    // Raster counters: h wraps every line, v advances on each h wrap and
    // wraps together with h at the end of the frame. Disabling parks the
    // raster at the frame top so re-enabling starts a clean frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Region decode; sync is the first segment of each line/frame
    always_comb begin
        hs_act = (h_cnt < H_SYNC_END);
        vs_act = (v_cnt < V_SYNC_END);
        h_in   = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
        v_in   = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
        de     = h_in && v_in;
        x      = de ? (h_cnt - H_ACT_START) : '0;
        y      = de ? (v_cnt - V_ACT_START) : '0;
        at_top = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_timing_pattern_gen
// Raster timing generator plus four-way test-pattern source.
//   sys_clk  : pixel clock
//   sys_rst  : synchronous active-high reset
//   vid      : master side of video_timing_pattern_gen_if
//              (en, pat_sel in; rgb_data, vid_de/hs/vs, pix_x/y, frame_start out)
// All outputs are registered one cycle after the counter state they describe.
// ---------------------------------------------------------------------------
module video_timing_pattern_gen #(
    parameter int          H_SYNC     = 44,
    parameter int          H_BACK     = 148,
    parameter int          H_ACTIVE   = 1920,
    parameter int          H_FRONT    = 88,
    parameter int          V_SYNC     = 5,
    parameter int          V_BACK     = 36,
    parameter int          V_ACTIVE   = 1080,
    parameter int          V_FRONT    = 4,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int          CNT_W      = 13,
    parameter logic [23:0] SOLID_RGB  = 24'h10B619,
    parameter int          CHECK_LOG2 = 5
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    video_timing_pattern_gen_if.master    vid
);
    import vtg_pkg::*;

    // Bar width without a divider; narrow screens fall back to 1-pixel bars
    localparam int               BAR_W    = (H_ACTIVE / 8 >= 1) ? H_ACTIVE / 8 : 1;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    generate
        if (CHECK_LOG2 >= CNT_W || CHECK_LOG2 < 0) begin : g_bad_check
            $error("video_timing_pattern_gen: CHECK_LOG2 must index into pix_x/pix_y");
        end
    endgenerate

    logic             hs_act;
    logic             vs_act;
    logic             de_pre;
    logic             at_top;
    logic [CNT_W-1:0] x_pre;
    logic [CNT_W-1:0] y_pre;

    pat_e             pat_q;
    logic [2:0]       bar_idx;
    logic [CNT_W-1:0] bar_px;
    logic [7:0]       grey;
    logic [23:0]      rgb_pre;

    vtg_counter #(
        .H_SYNC  (H_SYNC),   .H_BACK  (H_BACK),
        .H_ACTIVE(H_ACTIVE), .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),   .V_BACK  (V_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT (V_FRONT),
        .CNT_W   (CNT_W)
    ) u_counter (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .en     (vid.en),
        .hs_act (hs_act),
        .vs_act (vs_act),
        .de     (de_pre),
        .x      (x_pre),
        .y      (y_pre),
        .at_top (at_top)
    );

    // Pattern is captured only at the frame top so a frame never mixes
    // patterns. The bar counter tracks which bar the current pixel is in:
    // it restarts in blanking and steps every BAR_W active pixels, parking
    // on the last bar so leftover pixels of uneven widths stay black.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pat_q   <= PAT_SOLID;
            bar_idx <= '0;
            bar_px  <= '0;
        end else begin
            if (vid.en && at_top) begin
                pat_q <= pat_e'(vid.pat_sel);
            end
            if (!de_pre) begin
                bar_idx <= '0;
                bar_px  <= '0;
            end else if (bar_idx != 3'd7) begin
                if (bar_px == BAR_LAST) begin
                    bar_idx <= bar_idx + 3'd1;
                    bar_px  <= '0;
                end else begin
                    bar_px  <= bar_px + CNT_W'(1);
                end
            end
        end
    end

    // Pattern mux; blanking always forces black
    always_comb begin
        grey    = 8'(x_pre);
        rgb_pre = '0;
        if (de_pre) begin
            case (pat_q)
                PAT_SOLID: rgb_pre = SOLID_RGB;
                PAT_BARS:  rgb_pre = bar_colour(bar_idx);
                PAT_RAMP:  rgb_pre = {grey, grey, grey};
                PAT_CHECK: rgb_pre = (x_pre[CHECK_LOG2] ^ y_pre[CHECK_LOG2]) ? BAR_WHITE : BAR_BLACK;
                default:   rgb_pre = '0;
            endcase
        end
    end

    // Output registers; disabled generator presents the same idle levels as reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !vid.en) begin
            vid.rgb_data    <= '0;
            vid.vid_de      <= 1'b0;
            vid.vid_hs      <= ~HS_POL;
            vid.vid_vs      <= ~VS_POL;
            vid.pix_x       <= '0;
            vid.pix_y       <= '0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.rgb_data    <= rgb_pre;
            vid.vid_de      <= de_pre;
            vid.vid_hs      <= hs_act ? HS_POL : ~HS_POL;
            vid.vid_vs      <= vs_act ? VS_POL : ~VS_POL;
            vid.pix_x       <= x_pre;
            vid.pix_y       <= y_pre;
            vid.frame_start <= at_top;
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_pattern_gen
// Small raster: H 4/3/16/2 (25 clocks/line), V 2/1/4/1 (8 lines, 200 clocks
// per frame), HS active high, VS active low, 2-pixel checker squares.
// Cycle k after a release shows counter state s = k-1: h = s%25, v = s/25%8.
// Stimulus pushes hand-computed expectations tagged with the clock cycle at
// which they apply; a monitor samples each negedge and retires matches.
// ---------------------------------------------------------------------------
module tb_video_timing_pattern_gen;

    localparam int CNT_W = 13;

    typedef enum int {
        F_RGB, F_DE, F_HS, F_VS, F_X, F_Y, F_FS,
        M_DE_CNT, M_VS_LOW, M_FS_CNT, M_FS_PER, M_BLANK, M_CLR
    } fld_e;

    typedef struct {
        int          cyc;
        fld_e        fld;
        logic [31:0] val;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    exp_t sb[$];
    exp_t keep[$];

    int de_cnt    = 0;
    int vs_low    = 0;
    int fs_cnt    = 0;
    int fs_last   = 0;
    int fs_per    = 0;
    int blank_err = 0;

    video_timing_pattern_gen_if #(.CNT_W(CNT_W)) vif ();

    video_timing_pattern_gen #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(16), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_ACTIVE(4),  .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(CNT_W),
        .SOLID_RGB(24'h10B619), .CHECK_LOG2(1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .vid    (vif)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic string fieldName(input fld_e f);
        case (f)
            F_RGB:    return "rgb_data";
            F_DE:     return "vid_de";
            F_HS:     return "vid_hs";
            F_VS:     return "vid_vs";
            F_X:      return "pix_x";
            F_Y:      return "pix_y";
            F_FS:     return "frame_start";
            M_DE_CNT: return "de_cycles_per_frame";
            M_VS_LOW: return "vs_low_cycles_per_frame";
            M_FS_CNT: return "frame_starts_per_frame";
            M_FS_PER: return "frame_start_period";
            M_BLANK:  return "rgb_nonzero_in_blanking";
            default:  return "clear";
        endcase
    endfunction

    function automatic logic [31:0] sample(input fld_e f);
        case (f)
            F_RGB:    return {8'h00, vif.rgb_data};
            F_DE:     return {31'd0, vif.vid_de};
            F_HS:     return {31'd0, vif.vid_hs};
            F_VS:     return {31'd0, vif.vid_vs};
            F_X:      return 32'(vif.pix_x);
            F_Y:      return 32'(vif.pix_y);
            F_FS:     return {31'd0, vif.frame_start};
            M_DE_CNT: return 32'(de_cnt);
            M_VS_LOW: return 32'(vs_low);
            M_FS_CNT: return 32'(fs_cnt);
            M_FS_PER: return 32'(fs_per);
            M_BLANK:  return 32'(blank_err);
            default:  return 32'd0;
        endcase
    endfunction

    // Retire one scoreboard entry against the current DUT sample
    task automatic checkOutput(input exp_t e);
        logic [31:0] actual;
        if (e.fld == M_CLR) begin
            de_cnt = 0;
            vs_low = 0;
            fs_cnt = 0;
        end else begin
            actual = sample(e.fld);
            checks++;
            if (actual !== e.val) begin
                errors++;
                $display("[TB] FAIL %s @cycle %0d: got %0h, required %0h",
                         fieldName(e.fld), e.cyc, actual, e.val);
            end
        end
    endtask

    task automatic expectAt(input int c, input fld_e f, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] pat);
        sys_rst     = rst;
        vif.en      = en;
        vif.pat_sel = pat;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    // Monitor: accumulate per-frame statistics, then retire due entries
    always @(negedge sys_clk) begin
        if (cyc >= 1) begin
            if (vif.vid_de === 1'b1) de_cnt++;
            if (vif.vid_vs === 1'b0) vs_low++;
            if (vif.frame_start === 1'b1) begin
                fs_cnt++;
                fs_per  = cyc - fs_last;
                fs_last = cyc;
            end
            if (vif.vid_de !== 1'b1 && vif.rgb_data !== 24'h0) blank_err++;
            keep = {};
            foreach (sb[i]) begin
                if (sb[i].cyc == cyc) checkOutput(sb[i]);
                else keep.push_back(sb[i]);
            end
            sb = keep;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int r2;
        int r3;
        logic [23:0] bars [16];
        bars = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                 24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00,
                 24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
                 24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000};

        // Reset held for edges 1..3
        applyStimulus(1'b1, 1'b1, 2'd0);
        expectAt(2, F_HS, 0);  expectAt(2, F_VS, 1);
        expectAt(2, F_DE, 0);  expectAt(2, F_RGB, 0);
        expectAt(3, F_FS, 0);  expectAt(3, F_X, 0);
        expectAt(3, M_CLR, 0);
        waitUntil(3);
        r = 3;
        applyStimulus(1'b0, 1'b1, 2'd0);

        // First frame: timing and solid colour
        expectAt(r+1, F_FS, 1);   expectAt(r+1, F_HS, 1);
        expectAt(r+1, F_VS, 0);   expectAt(r+1, F_DE, 0);
        expectAt(r+2, F_FS, 0);
        expectAt(r+4, F_HS, 1);   expectAt(r+5, F_HS, 0);
        expectAt(r+50, F_VS, 0);  expectAt(r+51, F_VS, 1);
        expectAt(r+82, F_DE, 0);
        expectAt(r+83, F_DE, 1);  expectAt(r+83, F_X, 0);
        expectAt(r+83, F_Y, 0);   expectAt(r+83, F_RGB, 24'h10B619);
        expectAt(r+98, F_DE, 1);  expectAt(r+98, F_X, 15);
        expectAt(r+99, F_DE, 0);  expectAt(r+99, F_X, 0);
        expectAt(r+99, F_RGB, 0);
        expectAt(r+158, F_Y, 3);  expectAt(r+158, F_X, 0);
        expectAt(r+183, F_DE, 0);

        // Three consecutive frames of statistics
        for (int f = 1; f <= 3; f++) begin
            expectAt(r+200*f, M_DE_CNT, 64);
            expectAt(r+200*f, M_VS_LOW, 50);
            expectAt(r+200*f, M_FS_CNT, 1);
            expectAt(r+200*f, M_CLR, 0);
        end
        expectAt(r+201, F_FS, 1);
        expectAt(r+201, M_FS_PER, 200);
        expectAt(r+401, M_FS_PER, 200);

        // Colour bars in frame 2; first active pixel at r+283
        waitUntil(r+100);
        applyStimulus(1'b0, 1'b1, 2'd1);
        for (int x = 0; x < 16; x++) expectAt(r+283+x, F_RGB, {8'h00, bars[x]});
        expectAt(r+299, F_RGB, 0);
        expectAt(r+308, F_RGB, 24'hFFFFFF);

        // Frame 3 solid; switch to checkerboard partway through it
        waitUntil(r+300);
        applyStimulus(1'b0, 1'b1, 2'd0);
        expectAt(r+483, F_RGB, 24'h10B619);
        waitUntil(r+500);
        applyStimulus(1'b0, 1'b1, 2'd3);
        expectAt(r+508, F_RGB, 24'h10B619);
        expectAt(r+560, F_RGB, 24'h10B619);
        expectAt(r+683, F_RGB, 24'h000000);
        expectAt(r+685, F_RGB, 24'hFFFFFF);
        expectAt(r+733, F_RGB, 24'hFFFFFF);
        expectAt(r+735, F_RGB, 24'h000000);
        expectAt(r+735, F_DE, 1);

        // Reset pulse while counters sit at v=5, h=10 of frame 5
        waitUntil(r+935);
        applyStimulus(1'b1, 1'b1, 2'd3);
        expectAt(r+936, F_DE, 0);  expectAt(r+936, F_HS, 0);
        expectAt(r+936, F_VS, 1);  expectAt(r+936, F_RGB, 0);
        expectAt(r+936, F_X, 0);   expectAt(r+936, F_Y, 0);
        expectAt(r+936, F_FS, 0);
        waitUntil(r+936);
        r2 = r + 936;
        applyStimulus(1'b0, 1'b1, 2'd3);
        expectAt(r2+1, F_FS, 1);   expectAt(r2+1, F_HS, 1);
        expectAt(r2+1, F_VS, 0);
        expectAt(r2+83, F_DE, 1);  expectAt(r2+83, F_X, 0);
        expectAt(r2+85, F_RGB, 24'hFFFFFF);

        // Enable dropped for 40 cycles mid-line
        waitUntil(r2+110);
        applyStimulus(1'b0, 1'b0, 2'd3);
        expectAt(r2+111, F_DE, 0); expectAt(r2+111, F_X, 0);
        expectAt(r2+111, F_HS, 0); expectAt(r2+111, F_VS, 1);
        expectAt(r2+111, F_FS, 0); expectAt(r2+111, F_RGB, 0);
        expectAt(r2+150, F_DE, 0); expectAt(r2+150, F_VS, 1);
        waitUntil(r2+150);
        r3 = r2 + 150;
        applyStimulus(1'b0, 1'b1, 2'd3);
        expectAt(r3+1, F_FS, 1);   expectAt(r3+1, F_HS, 1);
        expectAt(r3+1, F_VS, 0);   expectAt(r3+2, F_FS, 0);
        expectAt(r3+83, F_DE, 1);  expectAt(r3+83, F_X, 0);
        expectAt(r3+83, F_Y, 0);
        expectAt(r3+201, F_FS, 1);

        // Grey ramp in the following frame
        waitUntil(r3+100);
        applyStimulus(1'b0, 1'b1, 2'd2);
        expectAt(r3+288, F_RGB, 24'h050505);
        expectAt(r3+298, F_RGB, 24'h0F0F0F);
        expectAt(r3+300, M_BLANK, 0);

        waitUntil(r3+305);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d unretired entries, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
